frame_buf_sel: RTL

Parametrised, registered frame-buffer selector for the display adapter pixel path. It chooses one of NUM_BUF pixel buffers, or a blank value, to drive the frame output. Buffer swaps and blanking changes take effect only at a frame boundary, so a frame never shows pixels from two buffers. It sits between the frame buffers and the display timing/serialiser stage.

---
 rtl/frame_pkg.sv | 24 ++
 rtl/swap_latch.sv | 81 ++++++++
 rtl/frame_buf_sel.sv | 130 +++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_pkg
// Brief    : Shared display-path types and defaults (state enum, pixel width,
//            blank value, buffer-index legality helper).
// Revision : 1.0 - initial release
// ============================================================================
package frame_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } frame_state_e;

  localparam int                  C_DATA_W    = 8;
  localparam logic [C_DATA_W-1:0] C_BLANK_VAL = '0;

  function automatic logic idx_legal(input int unsigned idx, input int unsigned num_buf);
    return idx < num_buf;
  endfunction

endpackage
`default_nettype wire

// File: rtl/swap_latch.sv
`default_nettype none
// ============================================================================
// Module   : swap_latch
// Brief    : Pending-swap register with acknowledge/error pulses. Optional
//            overwrite counter when FRAME_BUF_SEL_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module swap_latch
  import frame_pkg::*;
#(
  parameter int NUM_BUF = 2,
  parameter int IDX_W   = $clog2(NUM_BUF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_swap_req,
  input  logic [IDX_W-1:0] i_swap_idx,
  input  logic             i_frame_start,
  output logic             o_pending,
  output logic [IDX_W-1:0] o_pend_idx,
  output logic             o_apply,
  output logic             o_ack,
  output logic             o_err
`ifdef FRAME_BUF_SEL_STATS_EN
  ,
  output logic [7:0]       o_drop_count
`endif
);

  logic             w_take;
  logic             r_pending;
  logic [IDX_W-1:0] r_pend_idx;
  logic             r_ack;
  logic             r_err;

  assign w_take  = i_swap_req && idx_legal(32'(i_swap_idx), NUM_BUF);
  assign o_apply = i_frame_start && r_pending;

  // A request arriving with FrameStart is kept for the next frame, so it
  // wins over the clear caused by applying the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_pend_idx <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ack <= o_apply;
      r_err <= i_swap_req && !w_take;
      if (w_take) begin
        r_pending  <= 1'b1;
        r_pend_idx <= i_swap_idx;
      end else if (o_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

`ifdef FRAME_BUF_SEL_STATS_EN
  logic [7:0] r_drop_count;

  // Only a true overwrite counts; a request alongside an applying FrameStart
  // replaces nothing that would still have been shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= 8'd0;
    end else if (w_take && r_pending && !i_frame_start && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign o_drop_count = r_drop_count;
`endif

  assign o_pending  = r_pending;
  assign o_pend_idx = r_pend_idx;
  assign o_ack      = r_ack;
  assign o_err      = r_err;

endmodule
`default_nettype wire

// File: rtl/frame_buf_sel.sv
`default_nettype none
// ============================================================================
// Module   : frame_buf_sel
// Brief    : Registered frame-buffer selector; buffer swaps and blanking only
//            change at frame boundaries. FRAME_BUF_SEL_STATS_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buf_sel
  import frame_pkg::*;
#(
  parameter int                DATA_W    = C_DATA_W,
  parameter int                NUM_BUF   = 2,
  parameter int                IDX_W     = $clog2(NUM_BUF),
  parameter logic [DATA_W-1:0] BLANK_VAL = DATA_W'(C_BLANK_VAL)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_BUF*DATA_W-1:0] BufData,
  input  logic                      FrameStart,
  input  logic                      PixValid,
  input  logic                      SwapReq,
  input  logic [IDX_W-1:0]          SwapIdx,
  input  logic                      BlankReq,
  output logic [DATA_W-1:0]         FrameIn,
  output logic                      FrameValid,
  output logic [IDX_W-1:0]          ActiveIdx,
  output logic                      SwapPending,
  output logic                      SwapAck,
  output logic                      SwapErr
`ifdef FRAME_BUF_SEL_STATS_EN
  ,
  output logic [15:0]               FrameCount,
  output logic [7:0]                DropCount
`endif
);

  frame_state_e      r_state;
  frame_state_e      w_next_state;
  logic [IDX_W-1:0]  r_active_idx;
  logic [IDX_W-1:0]  w_next_idx;
  logic [IDX_W-1:0]  w_pend_idx;
  logic              w_pending;
  logic              w_apply;
  logic [DATA_W-1:0] w_buf [NUM_BUF];
  logic [DATA_W-1:0] w_pix;
  logic [DATA_W-1:0] r_frame_in;
  logic              r_frame_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUF; gi++) begin : g_unpack
      assign w_buf[gi] = BufData[gi*DATA_W +: DATA_W];
    end
  endgenerate

  swap_latch #(
    .NUM_BUF (NUM_BUF),
    .IDX_W   (IDX_W)
  ) u_swap_latch (
    .clk           (Clk),
    .rst           (Reset),
    .i_swap_req    (SwapReq),
    .i_swap_idx    (SwapIdx),
    .i_frame_start (FrameStart),
    .o_pending     (w_pending),
    .o_pend_idx    (w_pend_idx),
    .o_apply       (w_apply),
    .o_ack         (SwapAck),
    .o_err         (SwapErr)
`ifdef FRAME_BUF_SEL_STATS_EN
    ,
    .o_drop_count  (DropCount)
`endif
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The pixel sampled with FrameStart already belongs to the new frame, so
  // it is selected using the post-boundary state and buffer index.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = w_apply ? w_pend_idx : r_active_idx;
    w_pix        = BLANK_VAL;
    if (FrameStart) begin
      w_next_state = BlankReq ? BLANK : SHOW;
    end
    if ((w_next_state == SHOW) && PixValid) begin
      w_pix = w_buf[w_next_idx];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_active_idx  <= '0;
      r_frame_in    <= BLANK_VAL;
      r_frame_valid <= 1'b0;
    end else begin
      r_active_idx  <= w_next_idx;
      r_frame_in    <= w_pix;
      r_frame_valid <= PixValid;
    end
  end

`ifdef FRAME_BUF_SEL_STATS_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_count <= 16'd0;
    end else if (FrameStart) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign FrameCount = r_frame_count;
`endif

  assign FrameIn     = r_frame_in;
  assign FrameValid  = r_frame_valid;
  assign ActiveIdx   = r_active_idx;
  assign SwapPending = w_pending;

endmodule
`default_nettype wire
